// File: rtl/gcd_pkg.sv
// Shared FSM encoding and FIFO sizing helper for the GCD engine.
package gcd_pkg;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/gcd_result_fifo.sv
// Result FIFO: registered storage, head driven to zero while empty, no bypass.
module gcd_result_fifo
  import gcd_pkg::*;
#(
  parameter int DW    = 36,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [DW-1:0]             din,
  input  logic                      pop,
  output logic [DW-1:0]             dout,
  output logic [ptr_w(DEPTH):0]     count,
  output logic                      full,
  output logic                      empty
);

  localparam int PW = ptr_w(DEPTH);
  localparam logic [PW:0] C_FULL = (PW+1)'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [PW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign empty  = (r_cnt == '0);
  assign full   = (r_cnt == C_FULL);
  assign count  = r_cnt;
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);
  assign dout   = empty ? '0 : r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end

  // DEPTH is a power of two, so pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/gcd_engine_p.sv
// Subtract/swap GCD engine with tagged requests and a result FIFO.
// Define GCD_CYCLE_COUNT_EN to store and report a per-result iteration count.
module gcd_engine_p
  import gcd_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] start_a,
  input  logic [WIDTH-1:0] start_b,
  input  logic [TAG_W-1:0] start_tag,
  input  logic             EN_start,
  output logic             RDY_start,
  input  logic             EN_getResult,
  output logic [WIDTH-1:0] getResult,
  output logic [TAG_W-1:0] getResult_tag,
  output logic             RDY_getResult,
  output logic             busy
`ifdef GCD_CYCLE_COUNT_EN
  ,output logic [CNT_W-1:0] getResult_cycles
`endif
);

  localparam int PW = ptr_w(DEPTH);
  localparam logic [PW:0] C_DEPTH = (PW+1)'(DEPTH);
`ifdef GCD_CYCLE_COUNT_EN
  localparam int DW = WIDTH + TAG_W + CNT_W;
`else
  localparam int DW = WIDTH + TAG_W;
`endif

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [TAG_W-1:0] r_tag;
`ifdef GCD_CYCLE_COUNT_EN
  logic [CNT_W-1:0] r_cnt;
`endif

  logic             w_accept;
  logic             w_pop;
  logic             w_x_zero;
  logic             w_y_zero;
  logic             w_done;
  logic             w_push;
  logic [WIDTH-1:0] w_result;
  logic [DW-1:0]    w_din;
  logic [DW-1:0]    w_head;
  logic [PW:0]      w_count;
  logic             w_full;
  logic             w_empty;

  assign w_x_zero = (r_x == '0);
  assign w_y_zero = (r_y == '0);
  assign w_done   = (r_state == S_BUSY) && (w_x_zero || w_y_zero);
  assign w_push   = w_done && !w_full;
  assign w_result = w_x_zero ? r_y : r_x;

  // Gated by RST_N so the host never sees ready while reset is held
  assign RDY_start     = RST_N && (r_state == S_IDLE) && (w_count < C_DEPTH);
  assign RDY_getResult = !w_empty;
  assign busy          = (r_state == S_BUSY);
  assign w_accept      = EN_start && RDY_start;
  assign w_pop         = EN_getResult && RDY_getResult;

`ifdef GCD_CYCLE_COUNT_EN
  assign w_din            = {r_cnt, r_tag, w_result};
  assign getResult_cycles = w_head[WIDTH+TAG_W +: CNT_W];
`else
  assign w_din = {r_tag, w_result};
`endif
  assign getResult     = w_head[WIDTH-1:0];
  assign getResult_tag = w_head[WIDTH +: TAG_W];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_tag   <= '0;
`ifdef GCD_CYCLE_COUNT_EN
      r_cnt   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_x     <= start_a;
            r_y     <= start_b;
            r_tag   <= start_tag;
`ifdef GCD_CYCLE_COUNT_EN
            r_cnt   <= '0;
`endif
            r_state <= S_BUSY;
          end
        end
        default: begin
          if (w_x_zero || w_y_zero) begin
            r_state <= S_IDLE;
          end else begin
            // Keep x <= y so the subtract never underflows
            if (r_x > r_y) begin
              r_x <= r_y;
              r_y <= r_x;
            end else begin
              r_y <= r_y - r_x;
            end
`ifdef GCD_CYCLE_COUNT_EN
            if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
`endif
          end
        end
      endcase
    end
  end

  gcd_result_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (w_push),
    .din   (w_din),
    .pop   (w_pop),
    .dout  (w_head),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

endmodule

// File: tb/tb_gcd_engine_p.sv
// Scoreboard bench for gcd_engine_p (default parameters).
module tb_gcd_engine_p;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [31:0] start_a = '0;
  logic [31:0] start_b = '0;
  logic [3:0]  start_tag = '0;
  logic        EN_start = 1'b0;
  logic        RDY_start;
  logic        EN_getResult = 1'b0;
  logic [31:0] getResult;
  logic [3:0]  getResult_tag;
  logic        RDY_getResult;
  logic        busy;
`ifdef GCD_CYCLE_COUNT_EN
  logic [15:0] getResult_cycles;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [35:0] sb_q[$];

  always #5 CLK = ~CLK;

  gcd_engine_p dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .start_a       (start_a),
    .start_b       (start_b),
    .start_tag     (start_tag),
    .EN_start      (EN_start),
    .RDY_start     (RDY_start),
    .EN_getResult  (EN_getResult),
    .getResult     (getResult),
    .getResult_tag (getResult_tag),
    .RDY_getResult (RDY_getResult),
    .busy          (busy)
`ifdef GCD_CYCLE_COUNT_EN
    ,.getResult_cycles (getResult_cycles)
`endif
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timeout waiting on DUT", name);
  endtask

  function automatic logic [31:0] euclid(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Returns at the negedge right after the accept edge
  task automatic start_req(input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] t, input bit track);
    int n = 0;
    while (!RDY_start && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    if (!RDY_start) timeout("start_rdy");
    start_a   = a;
    start_b   = b;
    start_tag = t;
    EN_start  = 1'b1;
    if (track) sb_q.push_back({t, euclid(a, b)});
    @(negedge CLK);
    EN_start = 1'b0;
  endtask

  task automatic wait_idle(output int lat);
    lat = 0;
    while (busy && lat < 2000) begin
      @(negedge CLK);
      lat++;
    end
    if (busy) timeout("wait_idle");
  endtask

  task automatic pop_one(input string name);
    logic [35:0] e;
    int n = 0;
    while (!RDY_getResult && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    if (!RDY_getResult) begin
      timeout(name);
    end else if (sb_q.size() == 0) begin
      chk({name, "_unexpected"}, 64'(RDY_getResult), 64'd0);
    end else begin
      e = sb_q.pop_front();
      chk({name, "_val"}, 64'(getResult), 64'(e[31:0]));
      chk({name, "_tag"}, 64'(getResult_tag), 64'(e[35:32]));
    end
    EN_getResult = 1'b1;
    @(negedge CLK);
    EN_getResult = 1'b0;
  endtask

  initial begin
    int lat;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("rst_rdy_start", 64'(RDY_start), 64'd1);
    chk("rst_rdy_get", 64'(RDY_getResult), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_result", 64'(getResult), 64'd0);
    chk("rst_tag", 64'(getResult_tag), 64'd0);

    // Reset while computing gcd(1000,1)
    start_req(32'd1000, 32'd1, 4'd2, 1'b0);
    repeat (3) @(negedge CLK);
    chk("midrst_busy_before", 64'(busy), 64'd1);
    #2 RST_N = 1'b0;
    #1;
    chk("inrst_busy", 64'(busy), 64'd0);
    chk("inrst_rdy_start", 64'(RDY_start), 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("midrst_rdy_start", 64'(RDY_start), 64'd1);
    chk("midrst_rdy_get", 64'(RDY_getResult), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_result", 64'(getResult), 64'd0);

    // gcd(12,8): five steps then push
    start_req(32'd12, 32'd8, 4'd3, 1'b1);
    wait_idle(lat);
    chk("g12_8_lat", 64'(lat), 64'd6);
    chk("g12_8_rdy", 64'(RDY_getResult), 64'd1);
`ifdef GCD_CYCLE_COUNT_EN
    chk("g12_8_cycles", 64'(getResult_cycles), 64'd5);
`endif
    pop_one("g12_8");
    chk("g12_8_empty", 64'(RDY_getResult), 64'd0);

    // Degenerate operands, no pops in between
    start_req(32'd0, 32'd5, 4'd1, 1'b1);
    wait_idle(lat);
    chk("deg_0_5_lat", 64'(lat), 64'd1);
`ifdef GCD_CYCLE_COUNT_EN
    chk("deg_0_5_cycles", 64'(getResult_cycles), 64'd0);
`endif
    start_req(32'd7, 32'd0, 4'd2, 1'b1);
    wait_idle(lat);
    chk("deg_7_0_lat", 64'(lat), 64'd1);
    start_req(32'd0, 32'd0, 4'd5, 1'b1);
    wait_idle(lat);
    chk("deg_0_0_lat", 64'(lat), 64'd1);
    repeat (3) pop_one("deg");
    chk("deg_empty", 64'(RDY_getResult), 64'd0);

    // Fill all four slots
    start_req(32'd17, 32'd5, 4'd4, 1'b1);
    start_req(32'd9, 32'd6, 4'd5, 1'b1);
    start_req(32'd8, 32'd8, 4'd6, 1'b1);
    start_req(32'd10, 32'd4, 4'd7, 1'b1);
    wait_idle(lat);
    chk("full_rdy_start", 64'(RDY_start), 64'd0);
    pop_one("full_pop");
    chk("full_rdy_after_pop", 64'(RDY_start), 64'd1);
    repeat (3) pop_one("full_drain");
    chk("full_empty", 64'(RDY_getResult), 64'd0);

    // Pop on the same edge as a push with two results queued
    start_req(32'd0, 32'd9, 4'd6, 1'b1);
    start_req(32'd0, 32'd4, 4'd7, 1'b1);
    wait_idle(lat);
    start_req(32'd12, 32'd8, 4'd8, 1'b1);
    repeat (5) @(negedge CLK);
    chk("pp_busy_before", 64'(busy), 64'd1);
    pop_one("pp_head");
    chk("pp_busy_after", 64'(busy), 64'd0);
    pop_one("pp_second");
    pop_one("pp_third");
    chk("pp_empty", 64'(RDY_getResult), 64'd0);

    // Start while busy and pop while empty are both ignored
    start_req(32'd30, 32'd1, 4'd9, 1'b1);
    start_a      = 32'd0;
    start_b      = 32'd0;
    start_tag    = 4'hf;
    EN_start     = 1'b1;
    EN_getResult = 1'b1;
    @(negedge CLK);
    EN_start     = 1'b0;
    EN_getResult = 1'b0;
    chk("ign_busy", 64'(busy), 64'd1);
    chk("ign_rdy_get", 64'(RDY_getResult), 64'd0);
    chk("ign_result", 64'(getResult), 64'd0);
    chk("ign_rdy_start", 64'(RDY_start), 64'd0);
    pop_one("ign_res");
    repeat (2) @(negedge CLK);
    chk("ign_empty", 64'(RDY_getResult), 64'd0);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gcd_engine_p.md
Name: gcd_engine_p

Overview:
Parametrised successor to the fixed 32-bit GCD core. It adds configurable operand width, tagged requests and a result FIFO of configurable depth. Concurrent start/getResult in one cycle is legal, unlike the previous generation, which required mutual exclusion. It sits behind the same method-style EN/RDY interface used by the top-level test wrappers and is driven by a host that may issue a new request while earlier results are still queued.

Parameters:
WIDTH, 32, operand and result width in bits (>= 2)
DEPTH, 4, result FIFO entries (power of two, >= 2)
TAG_W, 4, request tag width, returned with each result
CNT_W, 16, iteration-counter width (used only with GCD_CYCLE_COUNT_EN)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous reset, active low
start_a  in  WIDTH  operand a
start_b  in  WIDTH  operand b
start_tag  in  TAG_W  request tag
EN_start  in  1  start method enable
RDY_start  out  1  start method ready
EN_getResult  in  1  getResult method enable (pop)
getResult  out  WIDTH  GCD at FIFO head
getResult_tag  out  TAG_W  tag at FIFO head
RDY_getResult  out  1  FIFO non-empty
busy  out  1  engine in BUSY state
getResult_cycles  out  CNT_W  iteration count at head (only with GCD_CYCLE_COUNT_EN)

Behaviour:
- Reset (RST_N low, asynchronous) does the following:
  - state IDLE, FIFO empty, x/y/tag cleared.
  - All outputs 0 except RDY_start = 1 once RST_N deasserts.
- Reset mid-computation discards the in-flight request and all queued results.
- FSM states are IDLE and BUSY.
- Accept condition:
  - RDY_start = (state==IDLE) && (fifo_count < DEPTH).
  - A start fires when EN_start && RDY_start; EN_start while !RDY_start is ignored.
  - Accept edge: x<=start_a, y<=start_b, tag latched, iteration counter <= 0, state -> BUSY.
- BUSY, one step per cycle, priority order:
  1. x==0: push y, go IDLE.
  2. Else y==0: push x, go IDLE.
  3. Else x>y: swap x and y.
  4. Else: y <= y - x (unsigned, WIDTH bits, never underflows).
- The iteration counter increments on every swap or subtract step and saturates at 2^CNT_W-1.
- A push always succeeds: RDY_start guaranteed a free slot, and only pushes raise the count.
- getResult, getResult_tag and getResult_cycles show the registered FIFO head and drive 0 when empty.
- Pop occurs on EN_getResult && RDY_getResult; EN_getResult while empty is ignored.
- There is no bypass: a result pushed at edge N is poppable from cycle N+1.
- Simultaneous push and pop in one cycle:
  - Legal; count is unchanged and pointers wrap modulo DEPTH.
  - Pop while full makes RDY_start rise in the next cycle.
- Simultaneous EN_start and EN_getResult are both honoured in the same cycle.
- Latency from the accept edge to RDY_getResult high is (steps + 1) cycles.
  - Example gcd(12,8): steps are swap, sub, swap, sub, sub = 5, then push, so 6 cycles.
- Degenerate operands:
  - gcd(0,0)=0; gcd(0,b)=b; gcd(a,0)=a.
  - Each takes 1 cycle (immediate push) with count 0.

Optional Feature:
- Macro GCD_CYCLE_COUNT_EN.
- Defined:
  - The iteration counter is present and stored per FIFO entry.
  - getResult_cycles port exists and reports the head entry's count.
- Undefined:
  - No counter, no per-entry count storage, no getResult_cycles port.
  - All other behaviour is unchanged.

Decomposition:
- Package gcd_pkg holds:
  - state encoding localparams (S_IDLE=1'b0, S_BUSY=1'b1);
  - a function computing the FIFO pointer width, clog2(DEPTH).
- Sub-module gcd_result_fifo:
  - parametrised by data width (WIDTH+TAG_W[+CNT_W]) and DEPTH;
  - push, pop, head, count, full, empty;
  - asynchronous active-low reset.
- The top level keeps the FSM and datapath.

Test Plan:
- Reset while BUSY on gcd(1000,1) -> next cycle RDY_start=1, RDY_getResult=0, busy=0, getResult=0.
- start(12,8,tag=3) -> RDY_getResult rises 6 cycles after accept; getResult=4, tag=3, cycles=5 (with macro).
- start(0,5), then (7,0), then (0,0), no pops -> three entries popped in order: 5, 7, 0; each latency 1; counts 0.
- DEPTH=4, four requests gcd(17,5), gcd(9,6), gcd(8,8), gcd(10,4) without pops:
  - expect RDY_start=0 after the 4th push;
  - one pop returns 1 and RDY_start=1 next cycle.
- FIFO holding 2 results with engine finishing; EN_getResult asserted on the push cycle -> count stays 2; results in order, tags intact.
- EN_start while BUSY, and EN_getResult while empty -> both ignored; no state, count or output change.
